// File: rtl/dmem_pkg.sv
//==============================================================================
// dmem_pkg : shared types, MMIO offsets and byte-enable helper for data_mem_ctrl
// Rev 1.0
//==============================================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_e;

  localparam logic [3:0] MTIME_LO = 4'h0;
  localparam logic [3:0] MTIME_HI = 4'h4;
  localparam logic [3:0] TOHOST   = 4'h8;
  localparam logic [3:0] SCRATCH  = 4'hC;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3)
      MW_B, MW_BU: byte_en = 4'b0001 << a;
      MW_H, MW_HU: byte_en = a[1] ? 4'b1100 : 4'b0011;
      MW_W:        byte_en = 4'b1111;
      default:     byte_en = 4'b0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_sram.sv
//==============================================================================
// dmem_sram : byte-enabled synchronous RAM, read returns pre-write contents
// Rev 1.0
//==============================================================================
`default_nettype none

module dmem_sram #(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    AW          = $clog2(DEPTH_WORDS),
  parameter int    DW          = 32,
  parameter string INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH_WORDS];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
//==============================================================================
// data_mem_ctrl : MEM-stage data bus decoder to RAM + MMIO (mtime/tohost/scratch)
//                 with one-cycle aligned, extended load return
// Rev 1.0
//==============================================================================
`default_nettype none

module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int              size        = 32,
  parameter int              DEPTH_WORDS = 4096,
  parameter logic [size-1:0] MMIO_BASE   = 32'h8000_0000,
  parameter string           INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_mem_rw,
  input  logic [size-1:0] data_mem_addr_o,
  input  logic [size-1:0] data_mem_data_wr_data,
  input  logic [2:0]      data_mem_control,
  output logic [size-1:0] data_mem_data_rd_data,
  output logic            access_err_o,
  output logic [size-1:0] tohost_o,
  output logic            done_o
);

  localparam int            AW        = $clog2(DEPTH_WORDS);
  localparam logic [size:0] RAM_BYTES = (size+1)'(DEPTH_WORDS * 4);

  logic [size-1:0] mmio_off;
  region_e         region;
  logic            f3_bad, misaligned, err, store_ok;
  logic [3:0]      ram_we;
  logic [size-1:0] wdata_steer, mmio_rd_d, sram_rdata;

  logic [63:0]     mtime_q;
  logic [size-1:0] tohost_q, scratch_q, mmio_rd_q;
  logic            done_q, ld_q, err_q;
  region_e         region_q;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;

  assign mmio_off = data_mem_addr_o - MMIO_BASE;

  always_comb begin
    region = REG_NONE;
    if ({1'b0, data_mem_addr_o} < RAM_BYTES) region = REG_RAM;
    else if (mmio_off < size'(16))           region = REG_MMIO;
  end

  assign f3_bad     = data_mem_control inside {3'b011, 3'b110, 3'b111};
  assign misaligned = ((data_mem_control == MW_H || data_mem_control == MW_HU) && data_mem_addr_o[0])
                    || (data_mem_control == MW_W && data_mem_addr_o[1:0] != 2'b00);
  assign err        = f3_bad || misaligned || (region == REG_NONE);
  assign store_ok   = data_mem_rw && !reset && !err;
  assign ram_we     = (store_ok && region == REG_RAM)
                    ? byte_en(data_mem_control, data_mem_addr_o[1:0]) : 4'b0000;

  // Replicate narrow store data so the enabled lane always carries it.
  always_comb begin
    wdata_steer = data_mem_data_wr_data;
    case (data_mem_control)
      MW_B, MW_BU: wdata_steer = {4{data_mem_data_wr_data[7:0]}};
      MW_H, MW_HU: wdata_steer = {2{data_mem_data_wr_data[15:0]}};
      default:     wdata_steer = data_mem_data_wr_data;
    endcase
  end

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW),
    .DW         (size),
    .INIT_FILE  (INIT_FILE)
  ) u_sram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (data_mem_addr_o[AW+1:2]),
    .wdata_i(wdata_steer),
    .rdata_o(sram_rdata)
  );

  always_comb begin
    mmio_rd_d = '0;
    case ({mmio_off[3:2], 2'b00})
      MTIME_LO: mmio_rd_d = mtime_q[31:0];
      MTIME_HI: mmio_rd_d = mtime_q[63:32];
      TOHOST:   mmio_rd_d = tohost_q;
      SCRATCH:  mmio_rd_d = scratch_q;
      default:  mmio_rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q   <= '0;
      tohost_q  <= '0;
      scratch_q <= '0;
      done_q    <= 1'b0;
      mmio_rd_q <= '0;
      ld_q      <= 1'b0;
      err_q     <= 1'b0;
      region_q  <= REG_NONE;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
    end else begin
      mtime_q <= mtime_q + 64'd1;
      if (store_ok && region == REG_MMIO) begin
        if ({mmio_off[3:2], 2'b00} == TOHOST) begin
          tohost_q <= data_mem_data_wr_data;
          done_q   <= 1'b1;
        end
        if ({mmio_off[3:2], 2'b00} == SCRATCH) scratch_q <= data_mem_data_wr_data;
      end
      mmio_rd_q <= mmio_rd_d;
      ld_q      <= !data_mem_rw;
      err_q     <= err;
      region_q  <= region;
      off_q     <= data_mem_addr_o[1:0];
      f3_q      <= data_mem_control;
    end
  end

  logic [size-1:0] word;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  assign word   = (region_q == REG_MMIO) ? mmio_rd_q : sram_rdata;
  assign lane_b = word[8*off_q +: 8];
  assign lane_h = off_q[1] ? word[31:16] : word[15:0];

  // Stores and faulting accesses return zero so WB never sees stale data.
  always_comb begin
    data_mem_data_rd_data = '0;
    if (ld_q && !err_q) begin
      case (f3_q)
        MW_B:    data_mem_data_rd_data = {{(size-8){lane_b[7]}}, lane_b};
        MW_BU:   data_mem_data_rd_data = {{(size-8){1'b0}}, lane_b};
        MW_H:    data_mem_data_rd_data = {{(size-16){lane_h[15]}}, lane_h};
        MW_HU:   data_mem_data_rd_data = {{(size-16){1'b0}}, lane_h};
        MW_W:    data_mem_data_rd_data = word;
        default: data_mem_data_rd_data = '0;
      endcase
    end
  end

  assign access_err_o = err_q;
  assign tohost_o     = tohost_q;
  assign done_o       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
//==============================================================================
// tb_data_mem_ctrl : directed scoreboard bench for data_mem_ctrl
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic [2:0]  f3 = 3'b010;
  logic [31:0] rd;
  logic        err;
  logic [31:0] tohost;
  logic        done;

  data_mem_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .data_mem_rw          (rw),
    .data_mem_addr_o      (addr),
    .data_mem_data_wr_data(wd),
    .data_mem_control     (f3),
    .data_mem_data_rd_data(rd),
    .access_err_o         (err),
    .tohost_o             (tohost),
    .done_o               (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rd;
    logic        err;
    bit          chk_rd;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every response belongs to the request issued in an earlier cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        tests++;
        if (err !== e.err) begin
          fails++;
          $display("FAIL %s access_err: got %0b want %0b", e.nm, err, e.err);
        end
        if (e.chk_rd) begin
          tests++;
          if (rd !== e.rd) begin
            fails++;
            $display("FAIL %s rd_data: got %08h want %08h", e.nm, rd, e.rd);
          end
        end
      end
    end
  end

  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, input logic [31:0] e_rd, input logic e_err,
                     input bit chk, input string nm);
    @(posedge clk);
    #1;
    reset = r; rw = w; addr = a; wd = d; f3 = f;
    sb.push_back('{cyc, e_rd, e_err, chk, nm});
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f, input logic [31:0] e,
                    input logic e_err, input string nm);
    req(1'b0, 1'b0, a, 32'h0, f, e, e_err, 1'b1, nm);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                    input logic e_err, input string nm);
    req(1'b0, 1'b1, a, d, f, 32'h0, e_err, 1'b1, nm);
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 32'h0, 1'b0, 1'b0, "idle");
  endtask

  task automatic chk_out(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %08h want %08h", nm, got, want);
    end
  endtask

  initial begin
    req(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 32'h0, 1'b0, 1'b1, "reset0");
    req(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 32'h0, 1'b0, 1'b1, "reset1");
    idle();
    chk_out("tohost_reset", tohost, 32'h0);
    chk_out("done_reset", {31'h0, done}, 32'h0);

    st(32'h10, 32'hDEADBEEF, 3'b010, 1'b0, "sw_10");
    ld(32'h10, 3'b010, 32'hDEADBEEF, 1'b0, "lw_10");

    st(32'h13, 32'h00000080, 3'b000, 1'b0, "sb_13");
    ld(32'h13, 3'b000, 32'hFFFFFF80, 1'b0, "lb_13");
    ld(32'h13, 3'b100, 32'h00000080, 1'b0, "lbu_13");
    ld(32'h10, 3'b010, 32'h80ADBEEF, 1'b0, "lw_after_sb");

    st(32'h12, 32'h00008001, 3'b001, 1'b0, "sh_12");
    ld(32'h12, 3'b001, 32'hFFFF8001, 1'b0, "lh_12");
    ld(32'h12, 3'b101, 32'h00008001, 1'b0, "lhu_12");
    st(32'h11, 32'h00001234, 3'b001, 1'b1, "sh_mis");
    ld(32'h10, 3'b010, 32'h8001BEEF, 1'b0, "lw_after_shmis");
    ld(32'h12, 3'b010, 32'h0, 1'b1, "lw_mis");
    ld(32'h11, 3'b101, 32'h0, 1'b1, "lhu_mis");

    ld(32'h00020000, 3'b010, 32'h0, 1'b1, "lw_unmapped");
    ld(32'h10, 3'b011, 32'h0, 1'b1, "f3_011");
    st(32'h3FFC, 32'hA5A55A5A, 3'b010, 1'b0, "sw_top");
    ld(32'h3FFC, 3'b010, 32'hA5A55A5A, 1'b0, "lw_top");
    ld(32'h4000, 3'b010, 32'h0, 1'b1, "lw_past_ram");
    st(32'h4000, 32'h1, 3'b010, 1'b1, "sw_past_ram");

    st(32'h80000008, 32'h1, 3'b010, 1'b0, "sw_tohost1");
    idle();
    chk_out("tohost_1", tohost, 32'h1);
    chk_out("done_set", {31'h0, done}, 32'h1);
    ld(32'h80000008, 3'b010, 32'h1, 1'b0, "lw_tohost");
    st(32'h80000008, 32'h0, 3'b010, 1'b0, "sw_tohost0");
    idle();
    chk_out("tohost_0", tohost, 32'h0);
    chk_out("done_sticky", {31'h0, done}, 32'h1);
    st(32'h8000000C, 32'hCAFEF00D, 3'b010, 1'b0, "sw_scratch");
    ld(32'h8000000C, 3'b010, 32'hCAFEF00D, 1'b0, "lw_scratch");
    ld(32'h8000000F, 3'b000, 32'hFFFFFFCA, 1'b0, "lb_scratch");
    ld(32'h80000010, 3'b010, 32'h0, 1'b1, "lw_past_mmio");

    req(1'b1, 1'b1, 32'h10, 32'h12345678, 3'b010, 32'h0, 1'b0, 1'b1, "rst_store");
    ld(32'h80000000, 3'b010, 32'h0, 1'b0, "mtime_t0");
    chk_out("tohost_rst", tohost, 32'h0);
    chk_out("done_rst", {31'h0, done}, 32'h0);
    repeat (9) idle();
    ld(32'h80000000, 3'b010, 32'd10, 1'b0, "mtime_t10");
    ld(32'h80000004, 3'b010, 32'h0, 1'b0, "mtime_hi");
    ld(32'h10, 3'b010, 32'h8001BEEF, 1'b0, "lw_after_rst");
    idle();
    idle();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
